sequence_recall_checker: RTL

Reader side of the memory game's sequence interface. It captures the target sequence that the game-start writer streams in on `d`/`wn`/`we`. During the recall phase it steps through that sequence in order, checking each player entry on `sw` against the stored value when the input key is pressed. It maintains correct and incorrect counts and an integer percent-correct, which the score display consumes.

---
 rtl/memory_game_pkg.sv | 25 ++
 rtl/percent_divider.sv | 57 +++++
 rtl/sequence_recall_checker.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/memory_game_pkg.sv
// memory_game_pkg
// Shared definitions for the memory game: recall FSM state encoding,
// default sequence geometry and the score saturation limit.
// No ports.
package memory_game_pkg;

  localparam int DEPTH_DEF = 10;
  localparam int WIDTH_DEF = 10;

  localparam logic [6:0] SCORE_MAX = 7'd99;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ARMED,
    ST_COMPARE,
    ST_DIV,
    ST_DONE
  } state_t;

  // Increment that sticks at SCORE_MAX.
  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v >= SCORE_MAX) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/percent_divider.sv
// percent_divider
// Restoring divider by repeated subtraction, one subtraction per cycle.
// A quotient q takes q+1 cycles after start: q subtractions plus the final
// compare that finds the remainder below the divisor.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        load dividend/divisor and begin (restarts if already running)
//   dividend     DW-bit numerator
//   divisor      VW-bit denominator, must be non-zero
//   done         high during the last cycle of a division; quotient valid then
//   quotient     QW-bit result
module percent_divider #(
  parameter int DW = 14,
  parameter int VW = 8,
  parameter int QW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [QW-1:0] quotient
);

  logic [DW-1:0] rem;
  logic [VW-1:0] dvs;
  logic [QW-1:0] q;
  logic          running;
  logic [DW-1:0] dvs_ext;

  assign dvs_ext  = {{(DW-VW){1'b0}}, dvs};
  assign done     = running && (rem < dvs_ext);
  assign quotient = q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      dvs     <= '0;
      q       <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= dividend;
      dvs     <= divisor;
      q       <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (rem >= dvs_ext) begin
        rem <= rem - dvs_ext;
        q   <= q + QW'(1);
      end else begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sequence_recall_checker.sv
// sequence_recall_checker
// Captures the target sequence streamed in by the game-start writer, then
// checks each player entry against it in order and keeps the score.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   we, wn, d         writer load strobe, slot index, slot data
//   key_n             raw active-low player button (asynchronous)
//   sw                player entry
//   led               last latched player entry
//   hit, miss         one-cycle result pulses
//   correct/incorrect saturating match/mismatch counts (0..99)
//   percent           floor(100*correct/(correct+incorrect))
//   busy, done        state decodes: COMPARE/DIV, DONE
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_LOAD    | writer owns the memory; leave on we fall if length > 0
// ST_ARMED   | waiting for a press; the press latches sw
// ST_COMPARE | one cycle: score latched entry against mem[ptr]
// ST_DIV     | divider running; percent updated on exit
// ST_DONE    | whole sequence entered; hold until we rises
module sequence_recall_checker
  import memory_game_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [3:0]       wn,
  input  logic [WIDTH-1:0] d,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] led,
  output logic             hit,
  output logic             miss,
  output logic [6:0]       correct,
  output logic [6:0]       incorrect,
  output logic [6:0]       percent,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] entry;
  logic [3:0]       ptr;
  logic [3:0]       length;
  logic             we_d;
  logic             key_s1, key_s2, key_s3;

  logic             press;
  logic             wn_ok;
  logic             we_rise;
  logic [3:0]       wn_inc;
  logic [3:0]       len_base;
  logic             match;
  logic [6:0]       correct_nx;
  logic [6:0]       incorrect_nx;
  logic [13:0]      div_dividend;
  logic [7:0]       div_divisor;
  logic             div_start;
  logic             div_done;
  logic [6:0]       div_quotient;

  // key_s3 is the previous synchronized level, so press is a single-cycle
  // falling-edge strobe; a held key produces one press only.
  assign press    = key_s3 & ~key_s2;
  assign wn_ok    = ({1'b0, wn} < 5'(DEPTH));
  assign we_rise  = we & ~we_d;
  assign wn_inc   = wn + 4'd1;
  // A new load starts from an empty sequence on the cycle we rises.
  assign len_base = we_rise ? 4'd0 : length;

  assign match        = (entry == mem[ptr]);
  assign correct_nx   = match ? sat_inc(correct) : correct;
  assign incorrect_nx = match ? incorrect : sat_inc(incorrect);
  // The divider is fed the post-update counts so percent reflects this entry.
  assign div_dividend = 14'(correct_nx) * 14'd100;
  assign div_divisor  = {1'b0, correct_nx} + {1'b0, incorrect_nx};
  assign div_start    = (state == ST_COMPARE) && !we;

  assign busy = (state == ST_COMPARE) || (state == ST_DIV);
  assign done = (state == ST_DONE);

  percent_divider #(.DW(14), .VW(8), .QW(7)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk) begin
    if (we && wn_ok) mem[wn] <= d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_s3 <= 1'b1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_LOAD;
      entry     <= '0;
      led       <= '0;
      ptr       <= '0;
      length    <= '0;
      we_d      <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      correct   <= '0;
      incorrect <= '0;
      percent   <= '0;
    end else begin
      we_d <= we;
      hit  <= 1'b0;
      miss <= 1'b0;
      if (we) begin
        state     <= ST_LOAD;
        correct   <= '0;
        incorrect <= '0;
        percent   <= '0;
        if (wn_ok && (wn_inc > len_base)) length <= wn_inc;
        else                              length <= len_base;
      end else begin
        case (state)
          ST_LOAD: begin
            if (we_d && (length != 4'd0)) begin
              state <= ST_ARMED;
              ptr   <= '0;
            end
          end
          ST_ARMED: begin
            if (press) begin
              entry <= sw;
              led   <= sw;
              state <= ST_COMPARE;
            end
          end
          ST_COMPARE: begin
            hit       <= match;
            miss      <= ~match;
            correct   <= correct_nx;
            incorrect <= incorrect_nx;
            ptr       <= ptr + 4'd1;
            state     <= ST_DIV;
          end
          ST_DIV: begin
            if (div_done) begin
              percent <= div_quotient;
              state   <= (ptr == length) ? ST_DONE : ST_ARMED;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: state <= ST_LOAD;
        endcase
      end
    end
  end

endmodule
